// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared FSM state type and default memory depth
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH = 512;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant; a tie goes to the requester not granted last
module rr_arbiter2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = {valid1, valid0};
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter in front of a single-port data memory
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              mem_MemWrite,
  output logic              mem_MemRead,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writeData,
  input  logic [DATA_W-1:0] mem_readData,
  output logic              busy
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        grant;
  logic              last_grant;
  logic              lat_id;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              in_range;

  assign in_range = ({1'b0, lat_addr} < DEPTH_LIM);

  rr_arbiter2 u_rr (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|grant) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    rsp0_valid    = 1'b0;
    rsp0_rdata    = '0;
    rsp0_err      = 1'b0;
    rsp1_valid    = 1'b0;
    rsp1_rdata    = '0;
    rsp1_err      = 1'b0;
    mem_MemWrite  = 1'b0;
    mem_MemRead   = 1'b0;
    mem_address   = '0;
    mem_writeData = '0;
    busy          = (state != IDLE);
    case (state)
      // Ready is gated by reset so every output reads 0 while reset is held.
      IDLE: if (!reset) {req1_ready, req0_ready} = grant;
      ACCESS: begin
        mem_MemWrite  = lat_write && in_range;
        mem_MemRead   = !lat_write && in_range;
        mem_address   = lat_addr;
        mem_writeData = lat_wdata;
      end
      RESP: begin
        if (lat_id) begin
          rsp1_valid = 1'b1;
          rsp1_rdata = rdata_q;
          rsp1_err   = err_q;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_rdata = rdata_q;
          rsp0_err   = err_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      lat_id     <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            lat_id    <= grant[1];
            lat_write <= grant[1] ? req1_write : req0_write;
            lat_addr  <= grant[1] ? req1_addr  : req0_addr;
            lat_wdata <= grant[1] ? req1_wdata : req0_wdata;
          end
        end
        ACCESS: begin
          err_q   <= !in_range;
          rdata_q <= (in_range && !lat_write) ? mem_readData : '0;
        end
        RESP: last_grant <= lat_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req0_write;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_write;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic          mem_MemWrite, mem_MemRead;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writeData, mem_readData;
  logic          busy;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] sim_mem [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int            vectors = 0;
  int            miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead),
    .mem_address(mem_address), .mem_writeData(mem_writeData),
    .mem_readData(mem_readData), .busy(busy)
  );

  // Memory model seen by the DUT.
  assign mem_readData = mem_MemRead ? sim_mem[mem_address[8:0]] : '0;
  always @(posedge clk) if (mem_MemWrite) sim_mem[mem_address[8:0]] <= mem_writeData;

  // Scoreboard pop plus per-cycle protocol invariants.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      vectors++;
      if ((req0_ready && req1_ready) || (mem_MemWrite && mem_MemRead) ||
          (!busy && (mem_MemWrite || mem_MemRead || mem_address != '0 || mem_writeData != '0)) ||
          (!rsp0_valid && (rsp0_rdata != '0 || rsp0_err)) ||
          (!rsp1_valid && (rsp1_rdata != '0 || rsp1_err))) begin
        miscompares++;
        $display("FAIL invariant @%0t: ready=%b%b strobes=%b%b busy=%b addr=%h wd=%h rsp0=%b/%h/%b rsp1=%b/%h/%b, required exclusive strobes/readys and idle zeros",
                 $time, req1_ready, req0_ready, mem_MemWrite, mem_MemRead, busy, mem_address,
                 mem_writeData, rsp0_valid, rsp0_rdata, rsp0_err, rsp1_valid, rsp1_rdata, rsp1_err);
      end
      if (rsp0_valid || rsp1_valid) begin
        vectors++;
        if (rsp0_valid && rsp1_valid) begin
          miscompares++;
          $display("FAIL rsp_both @%0t: rsp_valid=11, required one-hot", $time);
        end else if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rsp_unexpected @%0t: rsp_valid=%b%b, required none", $time, rsp1_valid, rsp0_valid);
        end else begin
          e = sb.pop_front();
          if (rsp1_valid !== e.id ||
              (rsp1_valid ? rsp1_rdata : rsp0_rdata) !== e.rdata ||
              (rsp1_valid ? rsp1_err : rsp0_err) !== e.err) begin
            miscompares++;
            $display("FAIL rsp_data @%0t: id=%b rdata=%h err=%b, required id=%b rdata=%h err=%b",
                     $time, rsp1_valid, rsp1_valid ? rsp1_rdata : rsp0_rdata,
                     rsp1_valid ? rsp1_err : rsp0_err, e.id, e.rdata, e.err);
          end
        end
      end
    end
  end

  task automatic clear_reqs();
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
  endtask

  task automatic drive_req(input bit id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!id) begin
      req0_valid = 1; req0_write = wr; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = 1; req1_write = wr; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic push_exp(input bit id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    bit   in;
    in = (a < 32'(DEPTH));
    if (wr && in) ref_mem[a[8:0]] = d;
    e.id    = id;
    e.rdata = (!wr && in) ? ref_mem[a[8:0]] : '0;
    e.err   = !in;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    clear_reqs();
    @(negedge clk);
    #1 reset = 0;
  endtask

  task automatic run_single(input bit id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    bit in;
    in = (a < 32'(DEPTH));
    @(negedge clk);
    drive_req(id, wr, a, d);
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== (id ? 2'b10 : 2'b01)) begin
      miscompares++;
      $display("FAIL %s grant: ready=%b%b, required id %0d only", tag, req1_ready, req0_ready, id);
    end
    push_exp(id, wr, a, d);
    @(negedge clk);
    clear_reqs();
    vectors++;
    if ({busy, mem_MemWrite, mem_MemRead} !== {1'b1, wr && in, !wr && in}) begin
      miscompares++;
      $display("FAIL %s access: busy/wr/rd=%b%b%b, required %b%b%b", tag, busy, mem_MemWrite,
               mem_MemRead, 1'b1, wr && in, !wr && in);
    end
    if (in) begin
      vectors++;
      if (mem_address !== a || (wr && mem_writeData !== d)) begin
        miscompares++;
        $display("FAIL %s mem_bus: addr=%h wdata=%h, required addr=%h wdata=%h", tag, mem_address, mem_writeData, a, d);
      end
    end
    @(negedge clk);
    vectors++;
    if ({rsp1_valid, rsp0_valid} !== (id ? 2'b10 : 2'b01)) begin
      miscompares++;
      $display("FAIL %s rsp_latency: rsp_valid=%b%b, required id %0d at t+2", tag, rsp1_valid, rsp0_valid, id);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_return: busy=%b, required 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1;
    clear_reqs();
    repeat (2) @(negedge clk);
    req0_valid = 1; req1_valid = 1;
    #1;
    vectors++;
    if ({busy, req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_MemWrite, mem_MemRead} !== 7'b0 ||
        mem_address !== '0 || mem_writeData !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b ready=%b%b rsp=%b%b strobes=%b%b, required all 0",
               busy, req1_ready, req0_ready, rsp1_valid, rsp0_valid, mem_MemWrite, mem_MemRead);
    end
    clear_reqs();
    @(negedge clk);
    #1 reset = 0;
  endtask

  task automatic test_store_load();
    run_single(0, 1, 36, 32'hDEADBEEF, "store36");
    run_single(1, 0, 36, '0, "load36");
    run_single(0, 1, 511, 32'h0BAD_F00D, "store511");
    run_single(1, 0, 511, '0, "load511");
  endtask

  task automatic test_out_of_range();
    run_single(0, 0, 512, '0, "load512");
    run_single(1, 1, 600, 32'h5555_AAAA, "store600");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    do_reset();
    @(negedge clk);
    drive_req(0, 0, 1, '0);
    drive_req(1, 0, 2, '0);
    for (int k = 0; k < 12; k++) begin
      #1;
      exp_rdy = (k % 3 != 0) ? 2'b00 : (((k / 3) % 2 == 1) ? 2'b10 : 2'b01);
      vectors++;
      if ({req1_ready, req0_ready} !== exp_rdy) begin
        miscompares++;
        $display("FAIL rr_order cycle %0d: ready=%b%b, required %b", k, req1_ready, req0_ready, exp_rdy);
      end
      if (exp_rdy != 2'b00) push_exp(exp_rdy[1], 0, exp_rdy[1] ? 2 : 1, '0);
      @(negedge clk);
    end
    clear_reqs();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drop_valid();
    @(negedge clk);
    drive_req(1, 1, 20, 32'h1111_2222);
    #2 clear_reqs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL drop_valid cycle %0d: busy=%b, required 0", k, busy);
      end
    end
  endtask

  task automatic test_busy_arrival();
    @(negedge clk);
    drive_req(0, 1, 10, 32'h1234_5678);
    #1 push_exp(0, 1, 10, 32'h1234_5678);
    @(negedge clk);
    clear_reqs();
    drive_req(1, 0, 10, '0);
    for (int k = 1; k <= 3; k++) begin
      #1;
      vectors++;
      if ({req1_ready, req0_ready} !== ((k == 3) ? 2'b10 : 2'b00)) begin
        miscompares++;
        $display("FAIL busy_arrival t+%0d: ready=%b%b, required %b", k, req1_ready, req0_ready,
                 (k == 3) ? 2'b10 : 2'b00);
      end
      if (k == 3) push_exp(1, 0, 10, '0);
      @(negedge clk);
    end
    clear_reqs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    run_single(0, 0, 3, '0, "pre_abort");
    @(negedge clk);
    drive_req(0, 1, 7, 32'hCAFE_0007);
    @(negedge clk);
    clear_reqs();
    vectors++;
    if (mem_MemWrite !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_setup: MemWrite=%b, required 1", mem_MemWrite);
    end
    #1 reset = 1;
    #1;
    vectors++;
    if ({mem_MemWrite, busy, rsp0_valid, rsp1_valid} !== 4'b0) begin
      miscompares++;
      $display("FAIL abort_drop: MemWrite/busy/rsp=%b%b%b%b, required 0000", mem_MemWrite, busy, rsp0_valid, rsp1_valid);
    end
    @(negedge clk);
    #1 reset = 0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_idle: busy=%b, required 0", busy);
    end
    drive_req(0, 0, 4, '0);
    drive_req(1, 0, 5, '0);
    #1;
    vectors++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL abort_tie: ready=%b%b, required 01", req1_ready, req0_ready);
    end
    push_exp(0, 0, 4, '0);
    @(negedge clk);
    clear_reqs();
    repeat (3) @(negedge clk);
    run_single(1, 0, 7, '0, "abort_nowrite");
  endtask

  task automatic test_drain();
    repeat (4) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      sim_mem[i] = 32'h1000_0000 + 32'(i * 3);
      ref_mem[i] = 32'h1000_0000 + 32'(i * 3);
    end
    test_reset();
    test_store_load();
    test_out_of_range();
    test_round_robin();
    test_drop_valid();
    test_busy_arrival();
    test_reset_abort();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 SHALL have parameter DEPTH, default 512, meaning number of valid word addresses (0..DEPTH-1).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have ports reqN_valid  input  1  and reqN_ready  output  1, where N=0,1: the request handshake.
REQ-007 SHALL have ports reqN_write  input  1  (1=store, 0=load), reqN_addr  input  ADDR_W  (word address), reqN_wdata  input  DATA_W.
REQ-008 SHALL have ports rspN_valid  output  1, rspN_rdata  output  DATA_W, rspN_err  output  1: the response to requester N.
REQ-009 SHALL have ports mem_MemWrite  output  1, mem_MemRead  output  1, mem_address  output  ADDR_W, mem_writeData  output  DATA_W: these drive the shared data memory.
REQ-010 SHALL have port mem_readData  input  DATA_W: combinational read data from the memory.
REQ-011 SHALL have port busy  output  1: high whenever the FSM is not in IDLE.

Function
REQ-012 SHALL implement a 3-state FSM with states IDLE, ACCESS and RESP.
REQ-013 IDLE with no request: SHALL stay in IDLE, with every reqN_ready low.
REQ-014 IDLE with at least one valid: SHALL assert reqN_ready combinationally for exactly one requester (the grant), latch that requester's write/addr/wdata and N, and go to ACCESS.
REQ-015 Grant rule: a single valid requester SHALL win; if both are valid, the requester not granted most recently SHALL win (round-robin via a last_grant bit).
REQ-016 ACCESS, in-range address (addr < DEPTH), store: SHALL drive mem_MemWrite=1 for exactly 1 cycle, with mem_address and mem_writeData taken from the latched values.
REQ-017 ACCESS, in-range address, load: SHALL drive mem_MemRead=1 for exactly 1 cycle and register mem_readData at the end of that cycle.
REQ-018 ACCESS, out-of-range address: SHALL assert neither mem strobe and SHALL record err=1.
REQ-019 ACCESS SHALL always go to RESP on the next cycle.
REQ-020 RESP: SHALL assert rspN_valid for exactly 1 cycle to the granted N only, present rspN_rdata (read data for an in-range load, otherwise 0) and rspN_err, update last_grant to N, and return to IDLE.
REQ-021 Latency: SHALL give the ready handshake in cycle t, the memory access in t+1 and the response in t+2; the next grant is possible no earlier than t+3.
REQ-022 SHALL hold mem_MemWrite and mem_MemRead low, and mem_address and mem_writeData at 0, in every state other than ACCESS.
REQ-023 SHALL never assert both mem strobes in the same cycle, and SHALL never assert both reqN_ready in the same cycle.
REQ-024 A requester dropping valid before it sees ready SHALL NOT be granted and SHALL NOT be recorded.
REQ-025 Requests arriving while busy SHALL see ready low and SHALL be serviced only after the FSM returns to IDLE.
REQ-026 rspN_rdata and rspN_err SHALL be 0 whenever rspN_valid is low.

Reset
REQ-027 Reset SHALL force: state=IDLE, last_grant=1 (so requester 0 wins the first tie), all latched registers=0, every output=0.
REQ-028 Reset asserted during ACCESS or RESP SHALL abort the transaction: no response is issued, and any memory strobe drops immediately.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, ACCESS, RESP) and the default DEPTH constant.
REQ-030 The round-robin grant logic SHALL be a sub-module, rr_arbiter2 (inputs: two valids and last_grant; output: a one-hot grant).

Verification
REQ-031 Store req0 addr=36 wdata=0xDEADBEEF -> ready0 in t, MemWrite=1 with address 36 in t+1, rsp0_valid=1 with err=0 in t+2.
REQ-032 Load req1 addr=36 after REQ-031, with the memory model returning 0xDEADBEEF -> MemRead=1 in t+1, rsp1_rdata=0xDEADBEEF in t+2.
REQ-033 Both valid continuously after reset -> grant order 0,1,0,1, one grant every 3 cycles, never two readys in one cycle.
REQ-034 Load req0 addr=512 (DEPTH=512) -> no mem strobe, rsp0_err=1, rsp0_rdata=0.
REQ-035 Reset asserted during ACCESS of a store -> MemWrite drops immediately, no rsp, busy=0, and the next tie goes to requester 0.
